// File: rtl/tri_scan.sv
// tri_scan: sequential triangle scan-converter.
// A start pulse in IDLE latches three unsigned vertices. The next cycle computes
// the bounding box and the doubled signed area. A non-degenerate triangle then
// has its bounding box walked row-major, one point per free output slot. Each
// point that passes the three edge-sign tests goes out on a valid/ready stream.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start                        begin a scan (only honoured in IDLE)
//   Ponto{1,2,3}{X,Y} [W]        triangle vertices, sampled with start
//   busy                         scan in progress
//   done                         one-cycle pulse at scan end
//   pix_valid/pix_ready          output handshake
//   pix_x, pix_y [W]             inside point coordinates
//   count [2W+1]                 points emitted in the current/last scan
module tri_scan #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] Ponto1X,
  input  logic [W-1:0] Ponto1Y,
  input  logic [W-1:0] Ponto2X,
  input  logic [W-1:0] Ponto2Y,
  input  logic [W-1:0] Ponto3X,
  input  logic [W-1:0] Ponto3Y,
  output logic         busy,
  output logic         done,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic [W-1:0] pix_x,
  output logic [W-1:0] pix_y,
  output logic [2*W:0] count
);

  localparam int EW = 2*W + 3;
  localparam logic [W-1:0] ONE_W   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W:0] ONE_CNT = {{(2*W){1'b0}}, 1'b1};
  localparam logic [EW-1:0] ZERO_E = {EW{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BBOX  = 3'd1,
    S_SCAN  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Edge function for edge a->b at T: (Tx-bx)(ay-by) - (ax-bx)(Ty-by).
  // The differences are exact in W+1 bits. The products are exact in 2W+2 bits.
  // The result is exact in 2W+3 bits, so no step wraps.
  function automatic logic [EW-1:0] edge_fn(
    input logic [W-1:0] ax, input logic [W-1:0] ay,
    input logic [W-1:0] bx, input logic [W-1:0] by,
    input logic [W-1:0] tx, input logic [W-1:0] ty
  );
    logic [W:0] d_tx, d_ay, d_ax, d_ty;
    logic signed [2*W+1:0] s_tx, s_ay, s_ax, s_ty, p0, p1;
    d_tx = {1'b0, tx} - {1'b0, bx};
    d_ay = {1'b0, ay} - {1'b0, by};
    d_ax = {1'b0, ax} - {1'b0, bx};
    d_ty = {1'b0, ty} - {1'b0, by};
    s_tx = $signed({{(W+1){d_tx[W]}}, d_tx});
    s_ay = $signed({{(W+1){d_ay[W]}}, d_ay});
    s_ax = $signed({{(W+1){d_ax[W]}}, d_ax});
    s_ty = $signed({{(W+1){d_ty[W]}}, d_ty});
    p0 = s_tx * s_ay;
    p1 = s_ax * s_ty;
    return {p0[2*W+1], p0} - {p1[2*W+1], p1};
  endfunction

  function automatic logic [W-1:0] min3(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [W-1:0] c);
    logic [W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [W-1:0] c);
    logic [W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  state_t         r_state;
  logic [W-1:0]   r_p1x, r_p1y, r_p2x, r_p2y, r_p3x, r_p3y;
  logic [W-1:0]   r_xmin, r_xmax, r_ymax;
  logic [W-1:0]   r_cx, r_cy;
  logic           r_busy, r_done, r_pix_valid;
  logic [W-1:0]   r_pix_x, r_pix_y;
  logic [2*W:0]   r_count;

  logic [W-1:0]   w_xmin, w_xmax, w_ymin, w_ymax;
  logic [EW-1:0]  w_area, w_e12, w_e23, w_e31;
  logic           w_inside, w_free, w_last_col, w_last;

  assign w_xmin = min3(r_p1x, r_p2x, r_p3x);
  assign w_xmax = max3(r_p1x, r_p2x, r_p3x);
  assign w_ymin = min3(r_p1y, r_p2y, r_p3y);
  assign w_ymax = max3(r_p1y, r_p2y, r_p3y);

  // Doubled signed area: the 1->2 edge function evaluated at vertex 3.
  assign w_area = edge_fn(r_p1x, r_p1y, r_p2x, r_p2y, r_p3x, r_p3y);

  assign w_e12 = edge_fn(r_p1x, r_p1y, r_p2x, r_p2y, r_cx, r_cy);
  assign w_e23 = edge_fn(r_p2x, r_p2y, r_p3x, r_p3y, r_cx, r_cy);
  assign w_e31 = edge_fn(r_p3x, r_p3y, r_p1x, r_p1y, r_cx, r_cy);

  // Points on an edge (E==0) pass both sign groups, so either winding accepts them.
  assign w_inside = (!w_e12[EW-1] && !w_e23[EW-1] && !w_e31[EW-1]) ||
                    ((w_e12[EW-1] || (w_e12 == ZERO_E)) &&
                     (w_e23[EW-1] || (w_e23 == ZERO_E)) &&
                     (w_e31[EW-1] || (w_e31 == ZERO_E)));

  // The output slot is free when it is empty or its point is being taken now.
  assign w_free     = !r_pix_valid || pix_ready;
  assign w_last_col = (r_cx == r_xmax);
  assign w_last     = w_last_col && (r_cy == r_ymax);

  // Scan controller: state, vertex/bbox latches, walk cursor and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_p1x       <= '0;
      r_p1y       <= '0;
      r_p2x       <= '0;
      r_p2y       <= '0;
      r_p3x       <= '0;
      r_p3y       <= '0;
      r_xmin      <= '0;
      r_xmax      <= '0;
      r_ymax      <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_p1x   <= Ponto1X;
            r_p1y   <= Ponto1Y;
            r_p2x   <= Ponto2X;
            r_p2y   <= Ponto2Y;
            r_p3x   <= Ponto3X;
            r_p3y   <= Ponto3Y;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= S_BBOX;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_BBOX: begin
          r_xmin <= w_xmin;
          r_xmax <= w_xmax;
          r_ymax <= w_ymax;
          // The area is only needed for this decision, so it is used here
          // directly and not kept.
          if (w_area == ZERO_E) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cx    <= w_xmin;
            r_cy    <= w_ymin;
            r_state <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (w_free) begin
            if (w_inside) begin
              r_pix_x     <= r_cx;
              r_pix_y     <= r_cy;
              r_pix_valid <= 1'b1;
              r_count     <= r_count + ONE_CNT;
            end else begin
              r_pix_valid <= 1'b0;
            end
            if (w_last) begin
              r_state <= S_FLUSH;
            end else if (w_last_col) begin
              r_cx <= r_xmin;
              r_cy <= r_cy + ONE_W;
            end else begin
              r_cx <= r_cx + ONE_W;
            end
          end else begin
            r_state <= S_SCAN;
          end
        end

        S_FLUSH: begin
          if (w_free) begin
            r_pix_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_state <= S_FLUSH;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_pix_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pix_valid = r_pix_valid;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign count     = r_count;

endmodule
